// File: rtl/rtype_exec_ctrl.sv
// Multi-cycle execute/write-back controller for MIPS R-type instructions.
// Steps IDLE -> READ -> EXEC -> WB and drives a 32x32 register file directly.
module rtype_exec_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Inst_Valid,
  input  logic [31:0]       Inst,
  output logic              Inst_Ready,
  output logic [ADDR_W-1:0] R_Addr_A,
  output logic [ADDR_W-1:0] R_Addr_B,
  input  logic [DATA_W-1:0] R_Data_A,
  input  logic [DATA_W-1:0] R_Data_B,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              Write_Reg,
  output logic              Done,
  output logic              ZF,
  output logic              OF,
  output logic              Illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  state_t            state;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] f_reg;

  logic [5:0]        ir_op;
  logic [5:0]        ir_funct;
  logic [4:0]        ir_shamt;
  logic [4:0]        ir_rd;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] alu_f;
  logic              alu_of;
  logic              alu_ill;

  assign ir_op    = ir[31:26];
  assign ir_funct = ir[5:0];
  assign ir_shamt = ir[10:6];
  assign ir_rd    = ir[15:11];

  // Addresses come straight from IR so they stay stable across every state.
  assign R_Addr_A = ADDR_W'(ir[25:21]);
  assign R_Addr_B = ADDR_W'(ir[20:16]);
  assign W_Addr   = ADDR_W'(ir_rd);
  assign W_Data   = f_reg;

  assign sum  = a_reg + b_reg;
  assign diff = a_reg - b_reg;

  always_comb begin
    alu_f   = '0;
    alu_of  = 1'b0;
    alu_ill = 1'b0;
    if (ir_op != 6'b000000) begin
      alu_ill = 1'b1;
    end else begin
      case (ir_funct)
        FN_ADD: begin
          alu_f  = sum;
          alu_of = (a_reg[DATA_W-1] == b_reg[DATA_W-1]) &&
                   (sum[DATA_W-1] != a_reg[DATA_W-1]);
        end
        FN_ADDU: alu_f = sum;
        FN_SUB: begin
          alu_f  = diff;
          alu_of = (a_reg[DATA_W-1] != b_reg[DATA_W-1]) &&
                   (diff[DATA_W-1] != a_reg[DATA_W-1]);
        end
        FN_SUBU: alu_f = diff;
        FN_AND:  alu_f = a_reg & b_reg;
        FN_OR:   alu_f = a_reg | b_reg;
        FN_XOR:  alu_f = a_reg ^ b_reg;
        FN_NOR:  alu_f = ~(a_reg | b_reg);
        FN_SLT:  alu_f = {{(DATA_W-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
        FN_SLTU: alu_f = {{(DATA_W-1){1'b0}}, (a_reg < b_reg)};
        FN_SLL:  alu_f = b_reg << ir_shamt;
        FN_SRL:  alu_f = b_reg >> ir_shamt;
        FN_SRA:  alu_f = DATA_W'($signed(b_reg) >>> ir_shamt);
        default: alu_ill = 1'b1;
      endcase
    end
  end

  // Write_Reg and Done are decided at the EXEC edge so they are clean registered pulses in WB.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      ir         <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      f_reg      <= '0;
      ZF         <= 1'b0;
      OF         <= 1'b0;
      Illegal    <= 1'b0;
      Inst_Ready <= 1'b1;
      Write_Reg  <= 1'b0;
      Done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Write_Reg <= 1'b0;
          Done      <= 1'b0;
          if (Inst_Valid && Inst_Ready) begin
            ir         <= Inst;
            Inst_Ready <= 1'b0;
            state      <= READ;
          end
        end
        READ: begin
          a_reg <= R_Data_A;
          b_reg <= R_Data_B;
          state <= EXEC;
        end
        EXEC: begin
          f_reg     <= alu_f;
          ZF        <= (alu_f == '0);
          OF        <= alu_of;
          Illegal   <= alu_ill;
          Write_Reg <= !alu_ill && !alu_of && (ir_rd != 5'd0);
          Done      <= 1'b1;
          state     <= WB;
        end
        WB: begin
          Write_Reg  <= 1'b0;
          Done       <= 1'b0;
          Inst_Ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// Directed self-checking bench for rtype_exec_ctrl with a behavioural 32x32
// register file attached; expected results are hand-computed constants.
module tb_rtype_exec_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Inst_Valid;
  logic [31:0] Inst;
  logic        Inst_Ready;
  logic [4:0]  R_Addr_A;
  logic [4:0]  R_Addr_B;
  logic [31:0] R_Data_A;
  logic [31:0] R_Data_B;
  logic [4:0]  W_Addr;
  logic [31:0] W_Data;
  logic        Write_Reg;
  logic        Done;
  logic        ZF;
  logic        OF;
  logic        Illegal;

  int errors = 0;
  int checks = 0;
  int wr_pulses = 0;
  int done_pulses = 0;

  logic [31:0] rf [32] = '{default: 32'h0};
  logic        pre_en = 1'b0;
  logic [4:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  rtype_exec_ctrl #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Inst_Valid (Inst_Valid),
    .Inst       (Inst),
    .Inst_Ready (Inst_Ready),
    .R_Addr_A   (R_Addr_A),
    .R_Addr_B   (R_Addr_B),
    .R_Data_A   (R_Data_A),
    .R_Data_B   (R_Data_B),
    .W_Addr     (W_Addr),
    .W_Data     (W_Data),
    .Write_Reg  (Write_Reg),
    .Done       (Done),
    .ZF         (ZF),
    .OF         (OF),
    .Illegal    (Illegal)
  );

  always #5 Clk = ~Clk;

  assign R_Data_A = rf[R_Addr_A];
  assign R_Data_B = rf[R_Addr_B];

  // Register file: bench preload port takes priority, $0 is never written.
  always @(posedge Clk) begin
    if (pre_en) rf[pre_addr] <= pre_data;
    else if (Write_Reg && W_Addr != 5'd0) rf[W_Addr] <= W_Data;
    if (Write_Reg) wr_pulses <= wr_pulses + 1;
    if (Done) done_pulses <= done_pulses + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic preload_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge Clk);
    pre_en = 1'b1; pre_addr = addr; pre_data = data;
    @(negedge Clk);
    pre_en = 1'b0;
  endtask

  // Drives one instruction through its full four-cycle life and checks each phase.
  task automatic apply_stimulus(input string tag, input logic [31:0] inst, input logic [31:0] exp_f,
                                input logic exp_we, input logic exp_zf, input logic exp_of,
                                input logic exp_ill, input logic [31:0] exp_rd_val);
    @(negedge Clk);
    check_output({tag, ".ready_idle"}, 32'(Inst_Ready), 32'd1);
    Inst_Valid = 1'b1; Inst = inst;
    @(negedge Clk);
    Inst_Valid = 1'b0; Inst = '0;
    check_output({tag, ".ready_read"}, 32'(Inst_Ready), 32'd0);
    check_output({tag, ".raddr_a"}, 32'(R_Addr_A), 32'(inst[25:21]));
    check_output({tag, ".raddr_b"}, 32'(R_Addr_B), 32'(inst[20:16]));
    @(negedge Clk);
    check_output({tag, ".done_exec"}, 32'(Done), 32'd0);
    @(negedge Clk);
    check_output({tag, ".waddr"}, 32'(W_Addr), 32'(inst[15:11]));
    check_output({tag, ".wdata"}, W_Data, exp_f);
    check_output({tag, ".write_reg"}, 32'(Write_Reg), 32'(exp_we));
    check_output({tag, ".done_wb"}, 32'(Done), 32'd1);
    check_output({tag, ".zf"}, 32'(ZF), 32'(exp_zf));
    check_output({tag, ".of"}, 32'(OF), 32'(exp_of));
    check_output({tag, ".illegal"}, 32'(Illegal), 32'(exp_ill));
    check_output({tag, ".ready_wb"}, 32'(Inst_Ready), 32'd0);
    @(negedge Clk);
    check_output({tag, ".done_after"}, 32'(Done), 32'd0);
    check_output({tag, ".we_after"}, 32'(Write_Reg), 32'd0);
    check_output({tag, ".rf_rd"}, rf[inst[15:11]], exp_rd_val);
  endtask

  initial begin
    int w0;
    int d0;
    Reset = 1'b1; Inst_Valid = 1'b0; Inst = '0;
    @(negedge Clk);
    check_output("rst.ready", 32'(Inst_Ready), 32'd1);
    check_output("rst.write_reg", 32'(Write_Reg), 32'd0);
    check_output("rst.done", 32'(Done), 32'd0);
    check_output("rst.raddr_a", 32'(R_Addr_A), 32'd0);
    check_output("rst.raddr_b", 32'(R_Addr_B), 32'd0);
    check_output("rst.waddr", 32'(W_Addr), 32'd0);
    check_output("rst.wdata", W_Data, 32'd0);
    check_output("rst.flags", {29'd0, ZF, OF, Illegal}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    preload_reg(5'd1, 32'd5);
    preload_reg(5'd2, 32'd7);
    apply_stimulus("add3", 32'h00221820, 32'd12, 1, 0, 0, 0, 32'd12);

    preload_reg(5'd1, 32'h7FFFFFFF);
    preload_reg(5'd2, 32'd1);
    apply_stimulus("add4_ovf", 32'h00222020, 32'h80000000, 0, 0, 1, 0, 32'h0);
    apply_stimulus("addu4", 32'h00222021, 32'h80000000, 1, 0, 0, 0, 32'h80000000);

    preload_reg(5'd1, 32'd9);
    apply_stimulus("sub0", 32'h00210022, 32'h0, 0, 1, 0, 0, 32'h0);

    apply_stimulus("bad_funct", 32'h0022383F, 32'h0, 0, 1, 0, 1, 32'h0);
    apply_stimulus("bad_op", 32'h20220005, 32'h0, 0, 1, 0, 1, 32'h0);
    apply_stimulus("add3_clr", 32'h00221820, 32'd10, 1, 0, 0, 0, 32'd10);

    preload_reg(5'd2, 32'h80000000);
    apply_stimulus("sra5", 32'h00022903, 32'hF8000000, 1, 0, 0, 0, 32'hF8000000);
    apply_stimulus("srl5", 32'h00022902, 32'h08000000, 1, 0, 0, 0, 32'h08000000);
    apply_stimulus("sll5", 32'h00022840, 32'h0, 1, 1, 0, 0, 32'h0);

    preload_reg(5'd1, 32'hFFFFFFFF);
    preload_reg(5'd2, 32'd1);
    apply_stimulus("slt6", 32'h0022302A, 32'd1, 1, 0, 0, 0, 32'd1);
    apply_stimulus("sltu6", 32'h0022302B, 32'd0, 1, 1, 0, 0, 32'd0);

    preload_reg(5'd1, 32'h80000000);
    apply_stimulus("sub7_ovf", 32'h00223822, 32'h7FFFFFFF, 0, 0, 1, 0, 32'h0);

    preload_reg(5'd1, 32'hF0F0F0F0);
    preload_reg(5'd2, 32'hFF00FF00);
    apply_stimulus("and8", 32'h00224024, 32'hF000F000, 1, 0, 0, 0, 32'hF000F000);
    apply_stimulus("nor8", 32'h00224027, 32'h000F000F, 1, 0, 0, 0, 32'h000F000F);
    apply_stimulus("xor8", 32'h00224026, 32'h0FF00FF0, 1, 0, 0, 0, 32'h0FF00FF0);
    apply_stimulus("subu8", 32'h00224023, 32'hF1EFF1F0, 1, 0, 0, 0, 32'hF1EFF1F0);

    // Back-to-back: Inst_Valid held; second instruction must wait for IDLE.
    @(negedge Clk);
    Inst_Valid = 1'b1; Inst = 32'h00224821;
    @(negedge Clk);
    Inst = 32'h00225025;
    check_output("b2b.ready_c1", 32'(Inst_Ready), 32'd0);
    @(negedge Clk);
    check_output("b2b.ready_c2", 32'(Inst_Ready), 32'd0);
    @(negedge Clk);
    check_output("b2b.ready_c3", 32'(Inst_Ready), 32'd0);
    check_output("b2b.waddr1", 32'(W_Addr), 32'd9);
    @(negedge Clk);
    check_output("b2b.ready_c4", 32'(Inst_Ready), 32'd1);
    @(negedge Clk);
    Inst_Valid = 1'b0; Inst = '0;
    check_output("b2b.ready_c5", 32'(Inst_Ready), 32'd0);
    check_output("b2b.rf9", rf[9], 32'hEFF1EFF0);
    @(negedge Clk);
    @(negedge Clk);
    check_output("b2b.waddr2", 32'(W_Addr), 32'd10);
    check_output("b2b.wdata2", W_Data, 32'hFFF0FFF0);
    check_output("b2b.done2", 32'(Done), 32'd1);
    @(negedge Clk);
    check_output("b2b.rf10", rf[10], 32'hFFF0FFF0);

    // Reset during EXEC of add $6 must abort with no write and no Done.
    preload_reg(5'd6, 32'hDEADBEEF);
    preload_reg(5'd1, 32'd5);
    preload_reg(5'd2, 32'd7);
    w0 = wr_pulses;
    d0 = done_pulses;
    @(negedge Clk);
    Inst_Valid = 1'b1; Inst = 32'h00223020;
    @(negedge Clk);
    Inst_Valid = 1'b0; Inst = '0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check_output("rstx.ready", 32'(Inst_Ready), 32'd1);
    check_output("rstx.write_reg", 32'(Write_Reg), 32'd0);
    check_output("rstx.done", 32'(Done), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    check_output("rstx.ready_after", 32'(Inst_Ready), 32'd1);
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    check_output("rstx.wr_pulses", 32'(wr_pulses - w0), 32'd0);
    check_output("rstx.done_pulses", 32'(done_pulses - d0), 32'd0);
    check_output("rstx.rf6", rf[6], 32'hDEADBEEF);
    check_output("rstx.ready_idle", 32'(Inst_Ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtype_exec_ctrl.md
Name: rtype_exec_ctrl

Overview:
- Multi-cycle execute/write-back controller for MIPS R-type instructions.
- Sits directly in front of the 32x32 register file. It drives the file's two read addresses and consumes the asynchronous read data. It computes the ALU result and drives the file's write port (W_Addr / Write_Reg / W_Data).
- Accepts one instruction at a time from the fetch/decode side over a valid/ready handshake.

Parameters:
- DATA_W, 32, datapath width (register width)
- ADDR_W, 5, register-file address width

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- Inst_Valid  in  1  upstream has an instruction on Inst
- Inst  in  32  instruction word: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]
- Inst_Ready  out  1  controller can accept an instruction
- R_Addr_A  out  5  register-file read port A address (rs)
- R_Addr_B  out  5  register-file read port B address (rt)
- R_Data_A  in  32  register-file port A data (combinational from file)
- R_Data_B  in  32  register-file port B data
- W_Addr  out  5  register-file write address (rd)
- W_Data  out  32  register-file write data
- Write_Reg  out  1  register-file write enable, one-cycle pulse
- Done  out  1  one-cycle pulse: instruction retired (written or suppressed)
- ZF  out  1  zero flag of last executed result
- OF  out  1  signed overflow of last add/sub
- Illegal  out  1  last accepted instruction was unsupported

Behaviour:
- States: IDLE -> READ -> EXEC -> WB -> IDLE. Encoding is free; no other states.
- IDLE:
  - Inst_Ready=1.
  - On Inst_Valid&&Inst_Ready at a rising edge, latch Inst into the instruction register IR and go to READ.
  - Otherwise stay in IDLE.
- READ:
  - R_Addr_A=IR.rs and R_Addr_B=IR.rt. Both are driven from IR in every state, so they stay stable.
  - At the edge, latch R_Data_A into A and R_Data_B into B. Go to EXEC.
- EXEC:
  - Compute F from A, B, IR.shamt and IR.funct. At the edge, latch F, ZF=(F==0), OF and Illegal. Go to WB.
- WB:
  - W_Addr=IR.rd and W_Data=F.
  - Write_Reg=1 only if Illegal==0, OF==0 and IR.rd!=0.
  - Done=1 for exactly this cycle regardless of whether the write is suppressed.
  - Next state is IDLE.
- Inst_Ready is 0 in READ/EXEC/WB. An instruction held on Inst_Valid during those states is not accepted until IDLE.
- Latency: accept at edge N. Write_Reg and Done are high during the cycle after edge N+2. The register file updates at edge N+3. Back-to-back throughput is 1 instruction per 4 cycles.
- Supported funct codes (op must be 000000, else Illegal=1):
  - 100000 add: signed; OF on overflow
  - 100001 addu: no OF
  - 100010 sub: signed; OF on overflow
  - 100011 subu
  - 100100 and
  - 100101 or
  - 100110 xor
  - 100111 nor
  - 101010 slt: signed compare, F=1 or 0
  - 101011 sltu: unsigned compare, F=1 or 0
  - 000000 sll: F=B<<shamt
  - 000010 srl: logical right shift
  - 000011 sra: arithmetic right shift
- Any other funct sets Illegal=1 and F=0.
- Overflow rules:
  - add: OF = (A[31]==B[31]) && (F[31]!=A[31]).
  - sub: OF = (A[31]!=B[31]) && (F[31]!=A[31]).
  - OF=0 for all other ops.
- All arithmetic is modulo 2^32.
- Flags (ZF, OF, Illegal) hold until the next EXEC updates them.
- Writes to rd=0 are always suppressed; Done still pulses.
- Reset:
  - State=IDLE; IR, A, B and F cleared to 0; ZF=0, OF=0, Illegal=0.
  - Outputs at reset: Inst_Ready=1, Write_Reg=0, Done=0, R_Addr_A/B=0, W_Addr=0, W_Data=0.
  - Reset asserted mid-operation, including during WB, aborts the instruction immediately: no write, no Done. After Reset deasserts, the controller is in IDLE.
- Write_Reg and Done are never high outside WB.

Test Plan:
- Preload $1=5, $2=7; send add $3,$1,$2 (Inst=0x00221820) -> Inst_Ready low 3 cycles; WB cycle shows W_Addr=3, W_Data=12, Write_Reg=1, Done=1; ZF=0, OF=0; $3 reads 12 afterwards.
- Preload $1=0x7FFFFFFF, $2=1; add $4,$1,$2 -> OF=1, Write_Reg=0 in WB, Done=1, $4 unchanged. Same operands with addu -> $4=0x80000000, OF=0.
- sub $0,$1,$1 with $1=9 -> F=0, ZF=1, Write_Reg=0, Done=1; $0 stays 0.
- Inst funct=111111 -> Illegal=1, no write, Done=1. Next valid or instruction clears Illegal=0.
- Preload $2=0x80000000; sra $5,$2,4 -> $5=0xF8000000. srl -> $5=0x08000000. sll $5,$2,1 -> $5=0.
- Shift/set-less-than check: slt with A=-1, B=1 -> F=1; sltu with the same operands -> F=0.
- Hold Inst_Valid high with two different instructions queued -> the second is accepted exactly 4 cycles after the first.
- Assert Reset during EXEC of an add $6 -> no Write_Reg or Done pulse; $6 unchanged; Inst_Ready=1 on the first cycle after Reset deasserts.
